external_bus_responder: RTL and testbench

Memory-side responder for the CPU's external bus. It accepts bus cycles from the core's address-bus and data-output registers and returns read data to the core's external data bus input. It services each cycle either from a one-entry read cache or through a request/acknowledge handshake to a backing memory, with a cycle-count timeout. It sits between the CPU top level and the memory/peripheral fabric.

---
 rtl/external_bus_responder.sv | 124 ++++++++++++
 tb/tb_external_bus_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/external_bus_responder.sv
// CPU external-bus responder: one-entry read cache in front of a req/ack memory port with timeout.
// Latency: read hit 1 cycle to cpu_done; miss/write 2 cycles minimum, TIMEOUT_CYCLES+1 on timeout.
// Backpressure: cpu_ready low outside IDLE; strobes arriving then are dropped and flagged in bus_error.
module external_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cpu_access,
    input  logic        cpu_write,
    input  logic [7:0]  address_high,
    input  logic [7:0]  address_low,
    input  logic [7:0]  data_from_cpu,
    output logic [7:0]  data_to_cpu,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic        cache_invalidate,
    input  logic        error_clear,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  tmo_cnt;
    logic        cache_vld;
    logic [15:0] cache_addr;
    logic [7:0]  cache_dat;
    logic [15:0] cpu_addr;
    logic        accept, hit, acked, timed_out, cache_match;

    assign cpu_addr  = {address_high, address_low};
    assign cpu_ready = (state == IDLE);
    assign cpu_done  = (state == DONE);

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        hit         = 1'b0;
        acked       = 1'b0;
        timed_out   = 1'b0;
        cache_match = cache_vld && (cache_addr == mem_addr);
        case (state)
            IDLE: begin
                if (cpu_access) begin
                    accept    = 1'b1;
                    hit       = !cpu_write && cache_vld && (cache_addr == cpu_addr);
                    state_nxt = hit ? DONE : REQ;
                end
            end
            REQ: begin
                // ack takes priority over a coincident timeout
                if (mem_ack) begin
                    acked     = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_to_cpu <= 8'h00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            tmo_cnt     <= 8'h00;
            cache_vld   <= 1'b0;
            cache_addr  <= 16'h0000;
            cache_dat   <= 8'h00;
            bus_error   <= 1'b0;
        end else begin
            if (accept) begin
                if (hit) begin
                    data_to_cpu <= cache_dat;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= cpu_write;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= data_from_cpu;
                    tmo_cnt   <= 8'h00;
                end
            end
            if (state == REQ) begin
                if (acked || timed_out) mem_req <= 1'b0;
                else                    tmo_cnt <= tmo_cnt + 8'd1;
                if (acked && !mem_we) begin
                    data_to_cpu <= mem_rdata;
                    cache_vld   <= 1'b1;
                    cache_addr  <= mem_addr;
                    cache_dat   <= mem_rdata;
                end
                if (acked && mem_we && cache_match)     cache_dat   <= mem_wdata;
                if (timed_out && !mem_we)               data_to_cpu <= OPEN_BUS_VALUE;
                // a failed write leaves the cached copy untrustworthy
                if (timed_out && mem_we && cache_match) cache_vld   <= 1'b0;
            end
            if (cache_invalidate) cache_vld <= 1'b0;
            if (timed_out || (cpu_access && state != IDLE)) bus_error <= 1'b1;
            else if (error_clear)                           bus_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_external_bus_responder.sv
// Directed bench for external_bus_responder: hand-computed expectations checked with immediate assertions.
module tb_external_bus_responder;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cpu_access, cpu_write;
    logic [7:0]  address_high, address_low, data_from_cpu, data_to_cpu;
    logic        cpu_ready, cpu_done, mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack, cache_invalidate, error_clear, bus_error;

    int nvec = 0;
    int nerr = 0;
    int req_cycles;

    external_bus_responder #(.TIMEOUT_CYCLES(15), .OPEN_BUS_VALUE(8'hFF)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_access(cpu_access), .cpu_write(cpu_write),
        .address_high(address_high), .address_low(address_low),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cache_invalidate(cache_invalidate), .error_clear(error_clear),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] a, input logic wr, input logic [7:0] d);
        address_high  = a[15:8];
        address_low   = a[7:0];
        cpu_write     = wr;
        data_from_cpu = d;
        cpu_access    = 1'b1;
        tick();
        cpu_access = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; cpu_access = 1'b0; cpu_write = 1'b0;
        address_high = 8'h00; address_low = 8'h00; data_from_cpu = 8'h00;
        mem_rdata = 8'h00; mem_ack = 1'b0; cache_invalidate = 1'b0; error_clear = 1'b0;
        #3;
        chk("rst_ready", cpu_ready, 1);
        chk("rst_done", cpu_done, 0);
        chk("rst_data", data_to_cpu, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_err", bus_error, 0);
        tick(); nrst = 1'b1; tick();

        // read miss 1234, immediate ack with A5
        start(16'h1234, 1'b0, 8'h00);
        chk("miss_req", mem_req, 1);
        chk("miss_ready", cpu_ready, 0);
        chk("miss_addr", mem_addr, 16'h1234);
        chk("miss_we", mem_we, 0);
        chk("miss_done_early", cpu_done, 0);
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        tick(); mem_ack = 1'b0;
        chk("miss_req_drop", mem_req, 0);
        chk("miss_done", cpu_done, 1);
        chk("miss_data", data_to_cpu, 8'hA5);
        tick();
        chk("miss_ready_back", cpu_ready, 1);
        chk("miss_done_pulse", cpu_done, 0);

        // read hit 1234
        start(16'h1234, 1'b0, 8'h00);
        chk("hit_done", cpu_done, 1);
        chk("hit_req", mem_req, 0);
        chk("hit_data", data_to_cpu, 8'hA5);
        tick();

        // write-through 3C to 1234, ack in third REQ cycle
        start(16'h1234, 1'b1, 8'h3C);
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 8'h3C);
        tick();
        chk("wr_req_c2", mem_req, 1);
        tick();
        chk("wr_req_c3", mem_req, 1);
        chk("wr_we_c3", mem_we, 1);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        chk("wr_done", cpu_done, 1);
        chk("wr_req_drop", mem_req, 0);
        tick();
        start(16'h1234, 1'b0, 8'h00);
        chk("wt_hit_done", cpu_done, 1);
        chk("wt_hit_req", mem_req, 0);
        chk("wt_hit_data", data_to_cpu, 8'h3C);
        tick();

        // timeout on 00FF
        start(16'h00FF, 1'b0, 8'h00);
        req_cycles = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            req_cycles++;
            tick();
        end
        chk("tmo_req_cycles", 16'(req_cycles), 16'd15);
        chk("tmo_done", cpu_done, 1);
        chk("tmo_data", data_to_cpu, 8'hFF);
        chk("tmo_err", bus_error, 1);
        tick();

        // violation + error_clear together keeps the error set
        start(16'h0042, 1'b0, 8'h00);
        cpu_access = 1'b1; error_clear = 1'b1;
        tick();
        cpu_access = 1'b0; error_clear = 1'b0;
        chk("set_clear_err", bus_error, 1);
        mem_ack = 1'b1; mem_rdata = 8'h77; tick(); mem_ack = 1'b0;
        chk("viol_fill_done", cpu_done, 1);
        tick();
        error_clear = 1'b1; tick(); error_clear = 1'b0;
        chk("clear_err", bus_error, 0);
        // a strobe during DONE is a violation on its own
        start(16'h0042, 1'b0, 8'h00);
        chk("viol_hit_data", data_to_cpu, 8'h77);
        cpu_access = 1'b1; tick(); cpu_access = 1'b0;
        chk("viol_done_err", bus_error, 1);
        error_clear = 1'b1; tick(); error_clear = 1'b0;

        // invalidate coinciding with a fill wins
        start(16'h5555, 1'b0, 8'h00);
        mem_ack = 1'b1; mem_rdata = 8'h11; cache_invalidate = 1'b1;
        tick();
        mem_ack = 1'b0; cache_invalidate = 1'b0;
        chk("inv_fill_data", data_to_cpu, 8'h11);
        tick();
        start(16'h5555, 1'b0, 8'h00);
        chk("inv_remiss_req", mem_req, 1);
        chk("inv_remiss_done", cpu_done, 0);
        mem_ack = 1'b1; mem_rdata = 8'h22; tick(); mem_ack = 1'b0;
        chk("inv_refill_data", data_to_cpu, 8'h22);
        tick();

        // reset while in REQ (5555 is cached with 22 at this point)
        start(16'h0100, 1'b0, 8'h00);
        chk("rreq_req", mem_req, 1);
        #2 nrst = 1'b0;
        #1;
        chk("rreq_req_async", mem_req, 0);
        chk("rreq_done", cpu_done, 0);
        tick(); nrst = 1'b1; tick();
        chk("rreq_ready", cpu_ready, 1);
        chk("rreq_no_done", cpu_done, 0);
        start(16'h5555, 1'b0, 8'h00);
        chk("rreq_cache_inv", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'h33; tick(); mem_ack = 1'b0;
        chk("rreq_refill", data_to_cpu, 8'h33);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
